// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: MDU occupancy FSM,
// data-memory wait, load-use/RAW stalls, branch flush. Optional perf counters: HFU_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int FWD_EN  = 1,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr_id,
  input  logic [4:0]  i_rs1_addr_id,
  input  logic [4:0]  i_rs2_addr_id,
  input  logic        i_rd_wren_ex,
  input  logic        i_mem_ren_ex,
  input  logic [4:0]  i_rd_addr_ex,
  input  logic [4:0]  i_rs1_addr_ex,
  input  logic [4:0]  i_rs2_addr_ex,
  input  logic        i_mdu_op_ex,
  input  logic        i_rd_wren_mem,
  input  logic [4:0]  i_rd_addr_mem,
  input  logic        i_mem_req_mem,
  input  logic        i_mem_ack,
  input  logic        i_rd_wren_wb,
  input  logic [4:0]  i_rd_addr_wb,
  input  logic        i_branch_taken,
  output logic        o_stall_pc,
  output logic        o_stall_if_id,
  output logic        o_stall_id_ex,
  output logic        o_stall_ex_mem,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_flush_ex_mem,
  output logic        o_flush_mem_wb,
  output logic [1:0]  o_forward_a,
  output logic [1:0]  o_forward_b,
  output logic        o_mdu_busy,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  typedef enum logic {IDLE, BUSY} mdu_state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;

  localparam bit             MDU_MULTI = (MDU_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = MDU_MULTI ? CNT_W'(MDU_LAT - 2) : '0;

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             use_rs1, use_rs2;
  logic             mem_wait, mdu_stall, ex_hit, mem_hit, raw_hit;
  logic             hazard, branch, wait_act;
  logic             unused_instr;

  assign unused_instr = ^i_instr_id[31:7];

  function automatic logic hit(input logic wren, input logic [4:0] rd, input logic [4:0] src);
    return wren && (rd != 5'd0) && (rd == src);
  endfunction

  always_comb begin
    // NOTE: defaults first so every path assigns both bits and no latch is inferred.
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (i_instr_id[6:0])
      OP_R, OP_S, OP_B:       begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default:                ;
    endcase
  end

  assign ex_hit  = (use_rs1 && hit(i_rd_wren_ex, i_rd_addr_ex, i_rs1_addr_id)) ||
                   (use_rs2 && hit(i_rd_wren_ex, i_rd_addr_ex, i_rs2_addr_id));
  assign mem_hit = (use_rs1 && hit(i_rd_wren_mem, i_rd_addr_mem, i_rs1_addr_id)) ||
                   (use_rs2 && hit(i_rd_wren_mem, i_rd_addr_mem, i_rs2_addr_id));
  // Without forwarding the consumer must wait until the producer reaches the write-through WB.
  assign raw_hit = (FWD_EN != 0) ? (i_mem_ren_ex && ex_hit) : (ex_hit || mem_hit);

  assign mem_wait  = i_mem_req_mem && !i_mem_ack;
  assign mdu_stall = !i_rst && (((state == IDLE) && i_mdu_op_ex && MDU_MULTI) ||
                                ((state == BUSY) && (cnt != '0)));
  assign wait_act  = !i_rst && mem_wait;
  assign hazard    = !i_rst && !mem_wait && !mdu_stall && raw_hit;
  assign branch    = !i_rst && !mem_wait && i_branch_taken;

  // A taken branch discards the dependent instruction, so the PC must take the redirect.
  assign o_stall_pc     = wait_act || mdu_stall || (hazard && !branch);
  assign o_stall_if_id  = wait_act || mdu_stall || (hazard && !branch);
  assign o_stall_id_ex  = wait_act || mdu_stall;
  assign o_stall_ex_mem = wait_act;
  assign o_flush_if_id  = branch;
  assign o_flush_id_ex  = branch || hazard;
  assign o_flush_ex_mem = mdu_stall && !mem_wait;
  assign o_flush_mem_wb = wait_act;

  always_comb begin
    o_forward_a = 2'b00;
    o_forward_b = 2'b00;
    if (!i_rst && (FWD_EN != 0)) begin
      if (hit(i_rd_wren_mem, i_rd_addr_mem, i_rs1_addr_ex))     o_forward_a = 2'b01;
      else if (hit(i_rd_wren_wb, i_rd_addr_wb, i_rs1_addr_ex))  o_forward_a = 2'b10;
      if (hit(i_rd_wren_mem, i_rd_addr_mem, i_rs2_addr_ex))     o_forward_b = 2'b01;
      else if (hit(i_rd_wren_wb, i_rd_addr_wb, i_rs2_addr_ex))  o_forward_b = 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_mdu_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_mdu_op_ex && MDU_MULTI) begin
          state      <= BUSY;
          cnt        <= CNT_LOAD;
          o_mdu_busy <= 1'b1;
        end
        BUSY: if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else if (!mem_wait) begin
          state      <= IDLE;
          o_mdu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HFU_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (o_stall_pc)    stall_cycles <= stall_cycles + 32'd1;
      if (o_flush_if_id) flush_count  <= flush_count + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles;
  assign o_flush_count  = flush_count;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule
